// File: rtl/rv_div_pkg.sv
// Shared encodings and constants for the RV32M iterative divider.
// Optional build macro used by the divider top: DIV_EARLY_EXIT_EN.
package rv_div_pkg;

   localparam int DIV_XLEN  = 32;
   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = 5;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   localparam logic [DIV_XLEN-1:0] MIN_INT  = 32'h8000_0000;
   localparam logic [DIV_XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] dvsr_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] rem_sh;
   logic [XLEN:0] diff;
   logic          ge;

   // Remainder stays below the divisor, so the shifted value fits in XLEN+1 bits.
   assign rem_sh = {rem_i, quo_i[XLEN-1]};
   assign diff   = rem_sh - {1'b0, dvsr_i};
   assign ge     = ~diff[XLEN];

   assign rem_o = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
   assign quo_o = {quo_i[XLEN-2:0], ge};

endmodule

// File: rtl/rv_div_unit.sv
// RV32M DIV/DIVU/REM/REMU radix-2 restoring divider with register-file writeback.
// Build option DIV_EARLY_EXIT_EN: finish in one cycle when |dividend| < |divisor|.
module rv_div_unit
   import rv_div_pkg::*;
#(
   parameter int XLEN       = DIV_XLEN,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [XLEN-1:0]       rs1_data,
   input  logic [XLEN-1:0]       rs2_data,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic                  wr_en,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic [XLEN-1:0]       wr_data
);

   div_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [XLEN-1:0]       rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
   logic [XLEN-1:0]       wr_data_q, wr_data_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d, wr_addr_q, wr_addr_d;
   logic                  is_rem_q, is_rem_d, negq_q, negq_d, negr_q, negr_d;

   logic            sgn_op, rem_op, a_neg, b_neg, div0, ovf, early;
   logic [XLEN-1:0] a_mag, b_mag, step_rem, step_quo, q_fix, r_fix;

   assign sgn_op = (op == OP_DIV) || (op == OP_REM);
   assign rem_op = (op == OP_REM) || (op == OP_REMU);
   assign a_neg  = sgn_op & rs1_data[XLEN-1];
   assign b_neg  = sgn_op & rs2_data[XLEN-1];
   assign a_mag  = a_neg ? -rs1_data : rs1_data;
   assign b_mag  = b_neg ? -rs2_data : rs2_data;
   assign div0   = (rs2_data == '0);
   assign ovf    = sgn_op && (rs1_data == MIN_INT) && (rs2_data == ALL_ONES);

`ifdef DIV_EARLY_EXIT_EN
   assign early = (a_mag < b_mag);
`else
   assign early = 1'b0;
`endif

   div_step #(.XLEN(XLEN)) u_step (
      .rem_i  (rem_q),
      .quo_i  (quo_q),
      .dvsr_i (dvsr_q),
      .rem_o  (step_rem),
      .quo_o  (step_quo)
   );

   assign q_fix = negq_q ? -step_quo : step_quo;
   assign r_fix = negr_q ? -step_rem : step_rem;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      wr_data_d = wr_data_q;
      wr_addr_d = wr_addr_q;
      rd_d      = rd_q;
      is_rem_d  = is_rem_q;
      negq_d    = negq_q;
      negr_d    = negr_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               rd_d     = rd_addr;
               is_rem_d = rem_op;
               negq_d   = a_neg ^ b_neg;
               negr_d   = a_neg;
               // Special results bypass the iteration and are raw, not sign-fixed.
               if (div0 || ovf || early) begin
                  state_d   = S_DONE;
                  wr_addr_d = rd_addr;
                  if (rem_op) wr_data_d = (div0 || early) ? rs1_data : '0;
                  else        wr_data_d = div0 ? ALL_ONES : (ovf ? MIN_INT : '0);
               end else begin
                  state_d = S_CALC;
                  cnt_d   = '0;
                  rem_d   = '0;
                  quo_d   = a_mag;
                  dvsr_d  = b_mag;
               end
            end
         end
         S_CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
               state_d   = S_DONE;
               wr_addr_d = rd_q;
               wr_data_d = is_rem_q ? r_fix : q_fix;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d   = S_IDLE;
         wr_data_d = wr_data_q;
         wr_addr_d = wr_addr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         wr_data_q <= '0;
         wr_addr_q <= '0;
         rd_q      <= '0;
         is_rem_q  <= 1'b0;
         negq_q    <= 1'b0;
         negr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         wr_data_q <= wr_data_d;
         wr_addr_q <= wr_addr_d;
         rd_q      <= rd_d;
         is_rem_q  <= is_rem_d;
         negq_q    <= negq_d;
         negr_q    <= negr_d;
      end
   end

   // A flush arriving in the DONE cycle still suppresses the writeback.
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE) && !flush;
   assign wr_en   = done && (wr_addr_q != '0);
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_rv_div_unit.sv
// Self-checking bench for rv_div_unit: directed cases plus random ops vs. an arithmetic model.
module tb_rv_div_unit;

   logic        clk = 1'b0;
   logic        rst_n, start, flush;
   logic [1:0]  op;
   logic [31:0] rs1_data, rs2_data;
   logic [4:0]  rd_addr;
   logic        busy, done, wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rv_div_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr), .flush(flush),
      .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // RISC-V division semantics straight from the ISA rules.
   function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int lat);
      logic [31:0] q, r;
      bit sgn;
      sgn = (o == 2'b00) || (o == 2'b10);
      lat = 33;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; lat = 1;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 32'd0; lat = 1;
      end else if (sgn) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
`ifdef DIV_EARLY_EXIT_EN
      if (b != 32'd0) begin
         longint ma, mb;
         ma = sgn ? longint'($signed(a)) : longint'(a);
         mb = sgn ? longint'($signed(b)) : longint'(b);
         if (ma < 0) ma = -ma;
         if (mb < 0) mb = -mb;
         if (ma < mb) lat = 1;
      end
`endif
      res = o[1] ? r : q;
   endfunction

   // Issue one op from IDLE, wait (bounded) for done, check result, then step into IDLE.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
      logic [31:0] exp;
      int lat, n;
      model(o, a, b, exp, lat);
      op = o; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      while (!done && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, ".lat"}, 32'(n), 32'(lat));
      check({tag, ".data"}, wr_data, exp);
      check({tag, ".wen"}, {31'd0, wr_en}, {31'd0, rd != 5'd0});
      check({tag, ".addr"}, {27'd0, wr_addr}, {27'd0, rd});
      @(posedge clk); #1;
      check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
   endtask

   // Start DIVU 1000/3, abort at cycle 10 by reset or flush; no writeback may ever appear.
   task automatic abort_run(input string tag, input bit use_flush);
      bit seen;
      op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 1'b0;
      for (int n = 1; n < 45; n++) begin
         if (n == 10) begin
            if (use_flush) flush = 1'b1;
            else           rst_n = 1'b0;
         end
         @(posedge clk); #1;
         if (done || wr_en) seen = 1'b1;
         if (n == 10) begin
            flush = 1'b0;
            rst_n = 1'b1;
            check({tag, ".busy_now"}, {31'd0, busy}, 32'd0);
            if (!use_flush) check({tag, ".wdata_rst"}, wr_data, 32'd0);
         end
      end
      check({tag, ".no_wb"}, {31'd0, seen}, 32'd0);
      check({tag, ".busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int n;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00;
      rs1_data = '0; rs2_data = '0; rd_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.busy", {31'd0, busy}, 32'd0);
      check("rst.done", {31'd0, done}, 32'd0);
      check("rst.wen", {31'd0, wr_en}, 32'd0);
      check("rst.addr", {27'd0, wr_addr}, 32'd0);
      check("rst.data", wr_data, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5);
      run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd5);
      run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 5'd6);
      run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6);
      run_op("div_5_0",    2'b00, 32'd5, 32'd0, 5'd1);
      run_op("remu_5_0",   2'b11, 32'd5, 32'd0, 5'd1);
      run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
      run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
      run_op("divu_rd0",   2'b01, 32'd9, 32'd3, 5'd0);
      run_op("divu_3_9",   2'b01, 32'd3, 32'd9, 5'd3);
      run_op("remu_3_9",   2'b11, 32'd3, 32'd9, 5'd3);
      run_op("rem_m3_9",   2'b10, 32'hFFFF_FFFD, 32'd9, 5'd3);
      run_op("divu_min_1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);

      abort_run("abort_rst", 1'b0);
      abort_run("abort_flush", 1'b1);

      // A second start mid-flight must not disturb the first operation.
      op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      while (!done && n < 60) begin
         if (n == 5) begin
            op = 2'b00; rs1_data = 32'd50; rs2_data = 32'd5; rd_addr = 5'd9; start = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         n++;
      end
      check("restart.lat", 32'(n), 32'd33);
      check("restart.data", wr_data, 32'd333);
      check("restart.addr", {27'd0, wr_addr}, 32'd7);
      @(posedge clk); #1;

      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: begin ra = $urandom; rb = $urandom; end
            1: begin ra = $urandom; rb = $urandom_range(1, 20); end
            2: begin ra = $urandom_range(0, 50); rb = $urandom; end
            default: begin
               ra = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : $urandom;
               rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd0;
            end
         endcase
         run_op($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom_range(0, 31)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
